// File: rtl/multi_debounce_if.sv
// Button bus between board-side inputs and the multi-channel debouncer.
// The master drives the raw buttons; the slave (the debouncer) returns the
// debounced levels and the one-cycle press/release pulses.
interface multi_debounce_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] pb_in;
    logic [CHANNELS-1:0] pb_level;
    logic [CHANNELS-1:0] pb_press;
    logic [CHANNELS-1:0] pb_release;
    logic                any_press;

    modport master (
        output pb_in,
        input  pb_level, pb_press, pb_release, any_press
    );

    modport slave (
        input  pb_in,
        output pb_level, pb_press, pb_release, any_press
    );
endinterface

// File: rtl/multi_debounce.sv
// multi_debounce: N-channel push-button debouncer on the slow scan clock.
// Each channel is synchronised by SYNC_STAGES flops, then a stability counter
// accepts a new level only after STABLE_CNT consecutive differing samples.
// Press/release pulses are registered and coincide with the level update.
// Optional feature macro: AUTO_REPEAT_EN (adds per-channel auto-repeat presses).
module multi_debounce #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CNT    = 4,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic              slow_clk,
    input  logic              rst_n,
    multi_debounce_if.slave   bus
);

    localparam int CW = $clog2(STABLE_CNT);

    // Reject parameter sets the counters cannot represent.
    if (CHANNELS < 1 || SYNC_STAGES < 2 || STABLE_CNT < 2 || STABLE_CNT > 255 ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_check
        $error("multi_debounce: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  s;
    logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  level_q, level_d;
    logic [CHANNELS-1:0]                  edge_press, edge_release, rep_press;
    logic [CHANNELS-1:0]                  press_q, press_d;
    logic [CHANNELS-1:0]                  release_q;
    logic                                 any_q;

    assign s = sync_q[SYNC_STAGES-1];

    // Plain flop chain synchroniser; stage 0 samples the asynchronous pins.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pb_in};
    end

    // Stability counting: any sample matching the current level restarts the count.
    always_comb begin
        cnt_d        = cnt_q;
        level_d      = level_q;
        edge_press   = '0;
        edge_release = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(STABLE_CNT - 1)) begin
                level_d[i]      = s[i];
                cnt_d[i]        = '0;
                edge_press[i]   = s[i];
                edge_release[i] = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    logic [CHANNELS-1:0][RW-1:0] rep_q, rep_d;

    // Repeat timer: first extra press REPEAT_DELAY cycles after the accepted
    // press, later ones every REPEAT_PERIOD by reloading the timer part-way.
    always_comb begin
        rep_d     = rep_q;
        rep_press = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!level_q[i] || edge_release[i]) begin
                rep_d[i] = '0;
            end else if (rep_q[i] == RW'(REPEAT_DELAY - 1)) begin
                rep_press[i] = 1'b1;
                rep_d[i]     = RW'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                rep_d[i] = rep_q[i] + 1'b1;
            end
        end
    end

    // Repeat timer register.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    assign rep_press = '0;
`endif

    assign press_d = edge_press | rep_press;

    // Counter, level and registered pulse outputs.
    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= edge_release;
            any_q     <= |press_d;
        end
    end

    assign bus.pb_level   = level_q;
    assign bus.pb_press   = press_q;
    assign bus.pb_release = release_q;
    assign bus.any_press  = any_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce with default parameters
// (4 channels, 2 sync stages, STABLE_CNT 4 -> 6 edges pin to level).
module tb_multi_debounce;

    logic slow_clk;
    logic rst_n;
    int   tests  = 0;
    int   failed = 0;

    multi_debounce_if #(.CHANNELS(4)) bus ();

    multi_debounce #(
        .CHANNELS(4), .SYNC_STAGES(2), .STABLE_CNT(4),
        .REPEAT_DELAY(64), .REPEAT_PERIOD(16)
    ) dut (
        .slow_clk (slow_clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    // Clock and reset defaults.
    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies pins, then checks press/release on every edge of a clean step.
    task automatic step(input string tag, input logic [3:0] pins,
                        input logic [3:0] exp_press, input logic [3:0] exp_rel);
        bus.pb_in = pins;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check({tag, "_press"}, 32'(bus.pb_press), (k == 6) ? 32'(exp_press) : 32'h0);
            check({tag, "_rel"},   32'(bus.pb_release), (k == 6) ? 32'(exp_rel) : 32'h0);
            check({tag, "_any"},   32'(bus.any_press), (k == 6) ? 32'(|exp_press) : 32'h0);
        end
    endtask

    initial begin
        int n_press;
        int n_rel;
        int press_at;
        logic [3:0] seen;
        logic [3:0] exp_p;

        // 1: reset with all buttons held
        rst_n     = 1'b0;
        bus.pb_in = 4'hF;
        tick();
        tick();
        check("rst_level",   32'(bus.pb_level),   32'h0);
        check("rst_press",   32'(bus.pb_press),   32'h0);
        check("rst_release", 32'(bus.pb_release), 32'h0);
        check("rst_any",     32'(bus.any_press),  32'h0);
        rst_n = 1'b1;
        step("t1", 4'hF, 4'hF, 4'h0);
        check("t1_level", 32'(bus.pb_level), 32'hF);
        tick();
        check("t1_press_off", 32'(bus.pb_press), 32'h0);

        // release all, giving a clean zero baseline (also a release check)
        step("rel_all", 4'h0, 4'h0, 4'hF);
        check("rel_all_level", 32'(bus.pb_level), 32'h0);

        // 2: bounce on ch0, final rise on the 5th applied value
        n_press  = 0;
        n_rel    = 0;
        press_at = 0;
        for (int k = 1; k <= 14; k++) begin
            bus.pb_in[0] = (k <= 4) ? ((k % 2) == 1) : 1'b1;
            tick();
            if (bus.pb_press[0]) begin
                n_press++;
                press_at = k;
            end
            if (bus.pb_release[0]) n_rel++;
        end
        check("bounce_press_count", 32'(n_press), 32'd1);
        check("bounce_press_edge",  32'(press_at), 32'd10);
        check("bounce_rel_count",   32'(n_rel), 32'd0);
        check("bounce_level",       32'(bus.pb_level), 32'h1);

        // 3: one-cycle spike on ch1 must be rejected
        seen = '0;
        bus.pb_in[1] = 1'b1;
        tick();
        bus.pb_in[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen = seen | {1'b0, bus.pb_level[1], bus.pb_press[1], bus.pb_release[1]};
            tick();
        end
        check("glitch_no_activity", 32'(seen), 32'h0);
        check("glitch_level", 32'(bus.pb_level), 32'h1);

        // 4: ch2 press then clean release
        step("t4_press", 4'b0101, 4'b0100, 4'h0);
        step("t4_rel",   4'b0001, 4'h0, 4'b0100);
        check("t4_level", 32'(bus.pb_level), 32'h1);

        // 5: ch0 and ch3 rise together
        step("t5_clr",   4'b0000, 4'h0, 4'b0001);
        step("t5_multi", 4'b1001, 4'b1001, 4'h0);
        check("t5_level", 32'(bus.pb_level), 32'h9);

        // 5b: reset in the middle of ch1 qualifying
        bus.pb_in = 4'b1011;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_level", 32'(bus.pb_level), 32'h0);
        check("midrst_press", 32'(bus.pb_press), 32'h0);
        check("midrst_any",   32'(bus.any_press), 32'h0);
        tick();
        rst_n = 1'b1;
        step("t5_requal", 4'b1011, 4'b1011, 4'h0);
        check("t5_requal_level", 32'(bus.pb_level), 32'hB);

        // 6: long hold; repeats only with the auto-repeat build
        for (int k = 1; k <= 120; k++) begin
            tick();
            exp_p = 4'h0;
`ifdef AUTO_REPEAT_EN
            if (k == 64 || k == 80 || k == 96 || k == 112) exp_p = 4'b1011;
`endif
            check("hold_press", 32'(bus.pb_press), 32'(exp_p));
            check("hold_any",   32'(bus.any_press), 32'(|exp_p));
        end
        step("t6_rel", 4'b0000, 4'h0, 4'b1011);
        for (int k = 0; k < 40; k++) begin
            tick();
            check("post_rel_press", 32'(bus.pb_press), 32'h0);
        end
        check("final_level", 32'(bus.pb_level), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
